// File: rtl/unpool2x_stream.sv
// Streaming 2x2 nearest-neighbour upsampler: each pooled pixel is emitted twice per row, and each row twice.
// Define UNPOOL_GRAD_EN for avgpool-backward mode, where each of the four copies carries in_data >>> 2.
module unpool2x_stream #(
  parameter int IN_WIDTH  = 14,
  parameter int IN_HEIGHT = 14,
  parameter int DW        = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
);

  localparam int CW = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
  localparam int RW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;

  typedef enum logic {ROW_A, ROW_B} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          ph_q, ph_d;
  logic          vld_q, vld_d;
  logic          last_q, last_d;
  logic [DW-1:0] lbuf [IN_WIDTH];

  logic          free;
  logic          load;
  logic          wr_lbuf;
  logic          col_end;
  logic          row_end;
  logic [DW-1:0] in_val;

`ifdef UNPOOL_GRAD_EN
  logic signed [DW-1:0] in_signed;
  assign in_signed = in_data;
  assign in_val    = in_signed >>> 2;
`else
  assign in_val = in_data;
`endif

  // The holding register can take a new pixel when empty or when its second copy leaves this cycle.
  assign free    = !vld_q || (out_ready && ph_q);
  assign col_end = (col_q == CW'(IN_WIDTH - 1));
  assign row_end = (row_q == RW'(IN_HEIGHT - 1));

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    hold_d   = hold_q;
    ph_d     = ph_q;
    vld_d    = vld_q;
    last_d   = last_q;
    in_ready = 1'b0;
    load     = 1'b0;
    wr_lbuf  = 1'b0;

    if (vld_q && out_ready && !ph_q) begin
      ph_d = 1'b1;
    end

    case (state_q)
      ROW_A: begin
        in_ready = free;
        if (in_valid && free) begin
          load    = 1'b1;
          wr_lbuf = 1'b1;
          hold_d  = in_val;
          last_d  = 1'b0;
          if (col_end) begin
            col_d   = '0;
            state_d = ROW_B;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ROW_B: begin
        if (free) begin
          load   = 1'b1;
          hold_d = lbuf[col_q];
          last_d = col_end && row_end;
          if (col_end) begin
            col_d   = '0;
            state_d = ROW_A;
            row_d   = row_end ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = ROW_A;
    endcase

    if (load) begin
      ph_d  = 1'b0;
      vld_d = 1'b1;
    end else if (free) begin
      ph_d  = 1'b0;
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ROW_A;
      col_q   <= '0;
      row_q   <= '0;
      hold_q  <= '0;
      ph_q    <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      hold_q  <= hold_d;
      ph_q    <= ph_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_lbuf) begin
      lbuf[col_q] <= in_val;
    end
  end

  assign out_data  = hold_q;
  assign out_valid = vld_q;
  assign out_last  = vld_q && ph_q && last_q;

endmodule

// File: tb/tb_unpool2x_stream.sv
// Bench for unpool2x_stream: 2x2, 14x14 and 1x1 instances; expectations follow UNPOOL_GRAD_EN when defined.
module tb_unpool2x_stream;

  localparam int AW = 2;
  localparam int AH = 2;
  localparam int BW = 14;
  localparam int BH = 14;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] a_in_data = '0, b_in_data = '0, c_in_data = '0;
  logic        a_in_valid = 1'b0, b_in_valid = 1'b0, c_in_valid = 1'b0;
  logic        a_in_ready, b_in_ready, c_in_ready;
  logic [15:0] a_out_data, b_out_data, c_out_data;
  logic        a_out_valid, b_out_valid, c_out_valid;
  logic        a_out_ready = 1'b1, b_out_ready = 1'b1;
  logic        c_out_ready = 1'b1;
  logic        a_out_last, b_out_last, c_out_last;

  int a_mode = 0;
  int b_mode = 0;

  unpool2x_stream #(.IN_WIDTH(AW), .IN_HEIGHT(AH), .DW(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_last(a_out_last));

  unpool2x_stream #(.IN_WIDTH(BW), .IN_HEIGHT(BH), .DW(16)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_last(b_out_last));

  unpool2x_stream #(.IN_WIDTH(1), .IN_HEIGHT(1), .DW(16)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_last(c_out_last));

  function automatic logic [15:0] xf(input logic [15:0] x);
    logic signed [15:0] s;
    s = x;
`ifdef UNPOOL_GRAD_EN
    return s >>> 2;
`else
    return s;
`endif
  endfunction

  // Output-ready drivers: 0 = always ready, 1 = toggle, 2 = random.
  always @(posedge clk) begin
    #1;
    case (a_mode)
      0: a_out_ready = 1'b1;
      1: a_out_ready = ~a_out_ready;
      default: a_out_ready = 1'($urandom_range(0, 1));
    endcase
    case (b_mode)
      0: b_out_ready = 1'b1;
      1: b_out_ready = ~b_out_ready;
      default: b_out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitors: record transfers, stall stability and the ordering rule that an input may only be
  // accepted once every output ahead of its first copy has left.
  int          a_cyc = 0, b_cyc = 0;
  logic [15:0] aq[$], bq[$], cq[$];
  bit          alq[$], blq[$], clq[$];
  int          atq[$];
  int          a_in_n = 0, a_out_n = 0, a_stab_bad = 0, a_ord_bad = 0;
  int          b_in_n = 0, b_out_n = 0, b_stab_bad = 0, b_ord_bad = 0;
  bit          a_stall = 0, b_stall = 0;
  logic [15:0] a_prev = '0, b_prev = '0;

  always @(negedge clk) begin
    a_cyc++;
    if (!rst_n) begin
      aq.delete(); alq.delete(); atq.delete();
      a_in_n = 0; a_out_n = 0; a_stall = 0;
    end else begin
      if (a_stall && (!a_out_valid || a_out_data != a_prev)) a_stab_bad++;
      if (a_in_ready && (a_out_n + int'(a_out_valid && a_out_ready)
                         != 4*AW*(a_in_n/AW) + 2*(a_in_n%AW))) a_ord_bad++;
      if (a_in_valid && a_in_ready) a_in_n++;
      if (a_out_valid && a_out_ready) begin
        aq.push_back(a_out_data); alq.push_back(a_out_last); atq.push_back(a_cyc);
        a_out_n++;
      end
      a_stall = a_out_valid && !a_out_ready;
      a_prev  = a_out_data;
    end
  end

  always @(negedge clk) begin
    b_cyc++;
    if (!rst_n) begin
      bq.delete(); blq.delete();
      b_in_n = 0; b_out_n = 0; b_stall = 0;
    end else begin
      if (b_stall && (!b_out_valid || b_out_data != b_prev)) b_stab_bad++;
      if (b_in_ready && (b_out_n + int'(b_out_valid && b_out_ready)
                         != 4*BW*(b_in_n/BW) + 2*(b_in_n%BW))) b_ord_bad++;
      if (b_in_valid && b_in_ready) b_in_n++;
      if (b_out_valid && b_out_ready) begin
        bq.push_back(b_out_data); blq.push_back(b_out_last);
        b_out_n++;
      end
      b_stall = b_out_valid && !b_out_ready;
      b_prev  = b_out_data;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      cq.delete(); clq.delete();
    end else if (c_out_valid && c_out_ready) begin
      cq.push_back(c_out_data); clq.push_back(c_out_last);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [15:0] px);
    int unsigned n = 0;
    bit ok = 0;
    a_in_data = px; a_in_valid = 1'b1;
    while (!ok && n < 500) begin @(negedge clk); ok = a_in_ready; n++; end
    align();
    a_in_valid = 1'b0; a_in_data = 16'($urandom);
    chk("a_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_b(input logic [15:0] px);
    int unsigned n = 0;
    bit ok = 0;
    b_in_data = px; b_in_valid = 1'b1;
    while (!ok && n < 500) begin @(negedge clk); ok = b_in_ready; n++; end
    align();
    b_in_valid = 1'b0; b_in_data = 16'($urandom);
    chk("b_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_c(input logic [15:0] px);
    int unsigned n = 0;
    bit ok = 0;
    c_in_data = px; c_in_valid = 1'b1;
    while (!ok && n < 500) begin @(negedge clk); ok = c_in_ready; n++; end
    align();
    c_in_valid = 1'b0; c_in_data = 16'($urandom);
    chk("c_accept", 32'(ok), 32'd1);
  endtask

  function automatic int qsize(input int w);
    return (w == 0) ? aq.size() : (w == 1) ? bq.size() : cq.size();
  endfunction

  task automatic wait_n(input int w, input int n, input string nm);
    int unsigned k = 0;
    while (qsize(w) < n && k < 5000) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    chk(nm, 32'(qsize(w)), 32'(n));
  endtask

  int exp2[16];

  task automatic check_frame_a(input int ofs, input int b, input string nm);
    for (int i = 0; i < 16; i++) begin
      chk({nm, "_data"}, 32'(aq[ofs+i]), 32'(xf(16'(exp2[i] + b))));
      chk({nm, "_last"}, 32'(alq[ofs+i]), 32'(i == 15));
    end
  endtask

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_rep;
    logic [15:0] exp_grad;
  } vec_t;

  vec_t        vt[6];
  logic [15:0] bin[$];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp2 = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};
    vt[0] = '{16'hFFF8, 16'hFFF8, 16'hFFFE};
    vt[1] = '{16'h0007, 16'h0007, 16'h0001};
    vt[2] = '{16'h8000, 16'h8000, 16'hE000};
    vt[3] = '{16'h7FFF, 16'h7FFF, 16'h1FFF};
    vt[4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    vt[5] = '{16'h0004, 16'h0004, 16'h0001};

    // Reset state
    @(negedge clk);
    chk("rst_a_valid", 32'(a_out_valid), 0);
    chk("rst_a_last",  32'(a_out_last),  0);
    chk("rst_a_data",  32'(a_out_data),  0);
    chk("rst_b_valid", 32'(b_out_valid), 0);
    chk("rst_c_valid", 32'(c_out_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_a_in_ready", 32'(a_in_ready), 1);
    align();

    // 2x2 frame, always ready: continuous output
    a_mode = 0;
    for (int i = 1; i <= 4; i++) send_a(16'(i));
    wait_n(0, 16, "f1_count");
    check_frame_a(0, 0, "f1");
    chk("f1_gap", 32'(atq[15] - atq[0]), 32'd15);

    // Same frame with toggling out_ready
    align();
    a_mode = 1;
    for (int i = 1; i <= 4; i++) send_a(16'(i));
    wait_n(0, 32, "f2_count");
    check_frame_a(16, 0, "f2");

    // Two frames back-to-back
    align();
    a_mode = 0;
    align();
    for (int i = 1; i <= 8; i++) send_a(16'(i));
    wait_n(0, 64, "f3_count");
    check_frame_a(32, 0, "f3a");
    check_frame_a(48, 4, "f3b");
    chk("f3_gap", 32'(atq[63] - atq[32]), 32'd31);
    chk("a_stable", 32'(a_stab_bad), 0);
    chk("a_order",  32'(a_ord_bad),  0);

    // Reset mid-frame discards the partial frame
    align();
    for (int i = 1; i <= 3; i++) send_a(16'(i + 20));
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(a_out_valid), 0);
    @(negedge clk);
    chk("mid_rst_valid2", 32'(a_out_valid), 0);
    align();
    rst_n = 1'b1;
    align();
    for (int i = 9; i <= 12; i++) send_a(16'(i));
    wait_n(0, 16, "f4_count");
    check_frame_a(0, 8, "f4");
    chk("a_order_post_rst", 32'(a_ord_bad), 0);

    // 1x1 table: each input becomes four outputs, last on the fourth
    align();
    for (int k = 0; k < 6; k++) begin
      logic [15:0] e;
`ifdef UNPOOL_GRAD_EN
      e = vt[k].exp_grad;
`else
      e = vt[k].exp_rep;
`endif
      send_c(vt[k].din);
      wait_n(2, 4*(k+1), "c_count");
      for (int j = 0; j < 4; j++) begin
        chk("c_data", 32'(cq[4*k+j]), 32'(e));
        chk("c_last", 32'(clq[4*k+j]), 32'(j == 3));
      end
      align();
    end

    // 14x14 random data with random backpressure and input gaps
    b_mode = 2;
    align();
    for (int i = 0; i < BW*BH; i++) begin
      logic [15:0] px;
      px = 16'($urandom);
      bin.push_back(px);
      if ($urandom_range(0, 3) == 0) align();
      send_b(px);
    end
    wait_n(1, 4*BW*BH, "b_count");
    begin
      int nlast = 0;
      for (int k = 0; k < 4*BW*BH; k++) begin
        int r, c;
        r = k / (2*BW);
        c = k % (2*BW);
        chk("b_data", 32'(bq[k]), 32'(xf(bin[(r/2)*BW + c/2])));
        nlast += int'(blq[k]);
      end
      chk("b_last_count", 32'(nlast), 32'd1);
      chk("b_last_final", 32'(blq[4*BW*BH-1]), 32'd1);
    end
    chk("b_stable", 32'(b_stab_bad), 0);
    chk("b_order",  32'(b_ord_bad),  0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
